riscv_dmem_responder: RTL and testbench

//  Memory-side responder for the RV32I data-memory port: accepts load/store requests from the

---
 rtl/riscv_dmem_responder_pkg.sv | 16 +
 rtl/riscv_dmem_array.sv | 36 +++
 rtl/riscv_dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_responder_pkg.sv
// rtl/riscv_dmem_responder_pkg.sv - shared constants and FSM encoding for the dmem responder
// Contents: default widths, default tohost address, wait-state limit, responder state type.
package riscv_dmem_responder_pkg;

    localparam int          DMEM_XLEN          = 32;
    localparam int          DMEM_ADDR_BIT_DEF  = 12;
    localparam int          DMEM_WAIT_MAX      = 15;
    localparam logic [31:0] DMEM_TOHOST_DEF    = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/riscv_dmem_array.sv
// rtl/riscv_dmem_array.sv - byte-lane write-enabled RAM, synchronous write, asynchronous read
// Ports:
//   clk       in   1            write clock
//   wr_en     in   1            write strobe for this cycle
//   byte_sel  in   XLEN/8       lane enables (lane k = bits 8k+7:8k)
//   addr      in   WORD_BITS    word index, shared by read and write
//   wr_data   in   XLEN         lane-aligned write data
//   rd_data   out  XLEN         word at addr (combinational)
module riscv_dmem_array #(
    parameter int XLEN      = 32,
    parameter int WORD_BITS = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [XLEN/8-1:0]     byte_sel,
    input  logic [WORD_BITS-1:0]  addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       rd_data
);

    logic [XLEN-1:0] mem [2**WORD_BITS];

    // Contents are deliberately not reset; only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < XLEN/8; k++) begin
                if (byte_sel[k]) begin
                    mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - RV32I data-memory responder with wait states and tohost MMIO
// Ports:
//   i_clk / i_rst                   clock, synchronous active-high reset
//   i_req_valid / o_req_ready       request handshake (ready only in IDLE)
//   i_req_wr_en, i_req_addr,        request: store flag, byte address,
//   i_req_byte_sel, i_req_wr_data   lane enables, lane-aligned store data
//   o_rsp_valid / i_rsp_ready       response handshake (held in RESP)
//   o_rsp_rd_data, o_rsp_err        load word (0 for stores/faults), access fault
//   o_tohost_valid, o_tohost_data   one-cycle pulse on tohost store, current tohost value
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int               XLEN          = DMEM_XLEN,
    parameter int               DMEM_ADDR_BIT = DMEM_ADDR_BIT_DEF,
    parameter int               WAIT_CYCLES   = 0,
    parameter logic [XLEN-1:0]  TOHOST_ADDR   = XLEN'(DMEM_TOHOST_DEF)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_wr_en,
    input  logic [XLEN-1:0]     i_req_addr,
    input  logic [3:0]          i_req_byte_sel,
    input  logic [XLEN-1:0]     i_req_wr_data,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_rd_data,
    output logic                o_rsp_err,
    output logic                o_tohost_valid,
    output logic [XLEN-1:0]     o_tohost_data
);

    localparam int         WORD_BITS = DMEM_ADDR_BIT - 2;
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request copy captured at accept; used while the transaction is waiting.
    logic            wr_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] rd_data_q;
    logic            err_q;
    logic            tohost_valid_q;
    logic [XLEN-1:0] tohost_data_q;

    // Operands of the access: with no wait states the access happens on the
    // accept edge itself, so the live request is used in IDLE.
    logic            acc_wr;
    logic [XLEN-1:0] acc_addr;
    logic [3:0]      acc_be;
    logic [XLEN-1:0] acc_wdata;
    logic            acc_tohost;
    logic            acc_in_range;
    logic            acc_ram;
    logic            acc_err;
    logic            enter_resp;
    logic            ram_we;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] tohost_merged;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------- decode
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_wr    = i_req_wr_en;
            acc_addr  = i_req_addr;
            acc_be    = i_req_byte_sel;
            acc_wdata = i_req_wr_data;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_be    = be_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_tohost   = (acc_addr == TOHOST_ADDR);
    assign acc_in_range = ((acc_addr >> DMEM_ADDR_BIT) == '0);
    assign acc_ram      = !acc_tohost && acc_in_range;
    assign acc_err      = !acc_tohost && !acc_in_range;

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    // Reset wins: a write due on the same edge as reset is suppressed.
    assign ram_we     = enter_resp && acc_wr && acc_ram && !i_rst;

    always_comb begin
        tohost_merged = tohost_data_q;
        for (int k = 0; k < 4; k++) begin
            if (acc_be[k]) begin
                tohost_merged[8*k +: 8] = acc_wdata[8*k +: 8];
            end
        end
    end

    riscv_dmem_array #(
        .XLEN      (XLEN),
        .WORD_BITS (WORD_BITS)
    ) u_array (
        .clk      (i_clk),
        .wr_en    (ram_we),
        .byte_sel (acc_be[XLEN/8-1:0]),
        .addr     (acc_addr[DMEM_ADDR_BIT-1:2]),
        .wr_data  (acc_wdata),
        .rd_data  (ram_rdata)
    );

    // --------------------------------------------- request latch, response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            rd_data_q      <= '0;
            err_q          <= 1'b0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
        end else begin
            tohost_valid_q <= 1'b0;
            if (state_q == ST_IDLE && i_req_valid) begin
                wr_q    <= i_req_wr_en;
                addr_q  <= i_req_addr;
                be_q    <= i_req_byte_sel;
                wdata_q <= i_req_wr_data;
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (acc_wr || acc_err) begin
                    rd_data_q <= '0;
                end else if (acc_tohost) begin
                    rd_data_q <= tohost_data_q;
                end else begin
                    rd_data_q <= ram_rdata;
                end
                if (acc_wr && acc_tohost) begin
                    tohost_data_q  <= tohost_merged;
                    tohost_valid_q <= 1'b1;
                end
            end else if (state_q == ST_RESP && i_rsp_ready) begin
                rd_data_q <= '0;
                err_q     <= 1'b0;
            end
        end
    end

    assign o_req_ready    = (state_q == ST_IDLE);
    assign o_rsp_valid    = (state_q == ST_RESP);
    assign o_rsp_rd_data  = rd_data_q;
    assign o_rsp_err      = err_q;
    assign o_tohost_valid = tohost_valid_q;
    assign o_tohost_data  = tohost_data_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - scoreboard bench for riscv_dmem_responder (WAIT_CYCLES 0 and 3)
module tb_riscv_dmem_responder;

    localparam logic [31:0] TOHOST = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst          = 2'b11;
    logic [1:0]  req_valid    = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr_en    = '0;
    logic [31:0] req_addr     [2];
    logic [3:0]  req_byte_sel [2];
    logic [31:0] req_wr_data  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready    = '0;
    logic [31:0] rsp_rd_data  [2];
    logic [1:0]  rsp_err;
    logic [1:0]  tohost_valid;
    logic [31:0] tohost_data  [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gen_dut
            riscv_dmem_responder #(
                .XLEN          (32),
                .DMEM_ADDR_BIT (12),
                .WAIT_CYCLES   ((g == 0) ? 0 : 3),
                .TOHOST_ADDR   (TOHOST)
            ) u_dut (
                .i_clk          (clk),
                .i_rst          (rst[g]),
                .i_req_valid    (req_valid[g]),
                .o_req_ready    (req_ready[g]),
                .i_req_wr_en    (req_wr_en[g]),
                .i_req_addr     (req_addr[g]),
                .i_req_byte_sel (req_byte_sel[g]),
                .i_req_wr_data  (req_wr_data[g]),
                .o_rsp_valid    (rsp_valid[g]),
                .i_rsp_ready    (rsp_ready[g]),
                .o_rsp_rd_data  (rsp_rd_data[g]),
                .o_rsp_err      (rsp_err[g]),
                .o_tohost_valid (tohost_valid[g]),
                .o_tohost_data  (tohost_data[g])
            );
        end
    endgenerate

    typedef struct {
        int          dut;
        logic [31:0] rd;
        logic        err;
        logic [31:0] th;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [2][1024];
    logic [31:0] th_m  [2];
    int          exp_pulses [2];
    int          got_pulses [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Reference model: applies the access at issue time and queues the response it implies.
    task automatic model_issue(input int k, input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t        e;
        logic [9:0]  w;
        e.dut = k; e.rd = '0; e.err = 1'b0;
        w = a[11:2];
        if (a == TOHOST) begin
            if (wr) begin
                th_m[k] = lane_merge(th_m[k], d, be);
                exp_pulses[k]++;
            end else begin
                e.rd = th_m[k];
            end
        end else if (a < 32'h0000_1000) begin
            if (wr) mem_m[k][w] = lane_merge(mem_m[k][w], d, be);
            else    e.rd = mem_m[k][w];
        end else begin
            e.err = 1'b1;
        end
        e.th = th_m[k];
        exp_q.push_back(e);
    endtask

    task automatic scramble(input int k);
        req_wr_en[k]    = 1'($urandom);
        req_addr[k]     = $urandom;
        req_byte_sel[k] = 4'($urandom);
        req_wr_data[k]  = $urandom;
    endtask

    task automatic txn(input int k, input logic wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input int hold);
        int          lat;
        bit          seen;
        bit          rdy_low;
        logic [31:0] rd0;
        @(posedge clk); #1;
        req_valid[k] = 1'b1; req_wr_en[k] = wr; req_addr[k] = a;
        req_byte_sel[k] = be; req_wr_data[k] = d;
        @(negedge clk);
        check("req_ready_idle", k, 32'(req_ready[k]), 32'd1);
        model_issue(k, wr, a, be, d);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        scramble(k);
        seen = 0; rdy_low = 1; lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                seen = 1;
                break;
            end
            if (req_ready[k]) rdy_low = 0;
            lat++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout dut%0d: got no response expected one within 40 cycles", k);
            return;
        end
        check("latency", k, 32'(lat), 32'(wait_of(k)));
        check("ready_low_wait", k, 32'(rdy_low), 32'd1);
        check("ready_low_resp", k, 32'(req_ready[k]), 32'd0);
        check("tohost_pulse", k, 32'(tohost_valid[k]), 32'((wr && a == TOHOST) ? 1 : 0));
        rd0 = rsp_rd_data[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            scramble(k);
            req_valid[k] = 1'b1;
            @(negedge clk);
            check("hold_valid", k, 32'(rsp_valid[k]), 32'd1);
            check("hold_rd_data", k, rsp_rd_data[k], rd0);
            check("hold_no_accept", k, 32'(req_ready[k]), 32'd0);
            if (h == 0) check("tohost_pulse_end", k, 32'(tohost_valid[k]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
    endtask

    task automatic reset_check(input int k);
        @(posedge clk); #1;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        @(negedge clk);
        check("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
        check("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
        check("rst_rsp_err", k, 32'(rsp_err[k]), 32'd0);
        check("rst_rd_data", k, rsp_rd_data[k], 32'd0);
        check("rst_tohost_valid", k, 32'(tohost_valid[k]), 32'd0);
        check("rst_tohost_data", k, tohost_data[k], 32'd0);
        th_m[k] = '0;
    endtask

    // Store accepted, then reset while the transaction is still waiting.
    task automatic reset_in_wait(input int k);
        bit quiet;
        @(posedge clk); #1;
        req_valid[k] = 1'b1; req_wr_en[k] = 1'b1; req_addr[k] = 32'h30;
        req_byte_sel[k] = 4'hF; req_wr_data[k] = 32'h55;
        @(negedge clk);
        check("rw_ready", k, 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        @(negedge clk);
        check("rw_req_ready", k, 32'(req_ready[k]), 32'd1);
        check("rw_rd_data", k, rsp_rd_data[k], 32'd0);
        th_m[k] = '0;
        quiet = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) quiet = 0;
        end
        check("rw_no_response", k, 32'(quiet), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (tohost_valid[k]) got_pulses[k]++;
                if (rsp_valid[k] && rsp_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_rsp dut%0d: got response expected none", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_dut", k, 32'(k), 32'(e.dut));
                        check("rsp_rd_data", k, rsp_rd_data[k], e.rd);
                        check("rsp_err", k, 32'(rsp_err[k]), 32'(e.err));
                        check("tohost_data", k, tohost_data[k], e.th);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = '0; req_byte_sel[k] = '0; req_wr_data[k] = '0;
            exp_pulses[k] = 0; got_pulses[k] = 0; th_m[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        for (int k = 0; k < 2; k++) begin
            reset_check(k);
            for (int w = 0; w < 16; w++) txn(k, 1'b1, 32'(w * 4), 4'hF, $urandom, 0);
            txn(k, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0);
            txn(k, 1'b0, 32'h10, 4'h0, 32'h0, 0);
            txn(k, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 0);
            txn(k, 1'b1, 32'h20, 4'h1, 32'h0000_00AA, 0);
            txn(k, 1'b1, 32'h20, 4'h4, 32'h00BB_0000, 0);
            txn(k, 1'b0, 32'h20, 4'hF, 32'h0, 1);
            txn(k, 1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF, 0);
            txn(k, 1'b0, 32'h24, 4'h0, 32'h0, 0);
            txn(k, 1'b0, 32'h2000, 4'hF, 32'h0, 0);
            txn(k, 1'b1, 32'h2000, 4'hF, 32'hFFFF_FFFF, 0);
            txn(k, 1'b0, 32'h0, 4'hF, 32'h0, 0);
            txn(k, 1'b1, TOHOST, 4'hF, 32'h0000_0001, 2);
            txn(k, 1'b0, TOHOST, 4'h0, 32'h0, 0);
            txn(k, 1'b0, 32'h10, 4'hF, 32'h0, 5);
            if (k == 1) begin
                reset_in_wait(k);
                txn(k, 1'b0, 32'h30, 4'hF, 32'h0, 0);
            end
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = TOHOST;
                else if (r == 1) a = 32'h1000 + ($urandom & 32'h0FFF_FFFC);
                else             a = 32'($urandom_range(0, 63));
                txn(k, 1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2));
            end
        end
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 0, 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 2; k++) check("tohost_pulse_count", k, 32'(got_pulses[k]), 32'(exp_pulses[k]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
